seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl_if.sv | 37 +++
 rtl/seq_detect_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, run-control and serial-stream bundle for seq_detect_ctrl.
// The bench or host drives through master; the detector sits on slave.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [4:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_threshold;
    logic               cfg_err;

    logic               start;
    logic               stop;

    logic               bit_valid;
    logic               bit_in;
    logic               bit_ready;

    logic               detect_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               busy;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_threshold,
        output start, stop, bit_valid, bit_in,
        input  cfg_err, bit_ready, detect_pulse, match_count, done, busy
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_threshold,
        input  start, stop, bit_valid, bit_in,
        output cfg_err, bit_ready, detect_pulse, match_count, done, busy
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with run control: counts matches of a configurable
// pattern (overlapping or not) and stops in DONE once a match threshold is hit.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic          clock,
    input logic          reset,
    seq_detect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Latched configuration; a run only ever looks at these copies.
    logic [MAX_LEN-1:0] pat_q;
    logic [4:0]         len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   thr_q;

    // Only MAX_LEN-1 past bits are kept: with the incoming bit that is a full window.
    logic [MAX_LEN-2:0] history;
    logic [4:0]         bits_seen;
    logic [CNT_W-1:0]   match_count;
    logic               detect_pulse;
    logic               cfg_err;

    logic [MAX_LEN-1:0] new_hist;
    logic [MAX_LEN-1:0] len_mask;
    logic [4:0]         seen_inc;
    logic [CNT_W-1:0]   count_inc;
    logic               accept;
    logic               hit;
    logic               thr_hit;
    logic               start_run;
    logic               cfg_idle;
    logic               cfg_bad;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        len_mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end

        new_hist  = {history, bus.bit_in};
        seen_inc  = (bits_seen < 5'(MAX_LEN)) ? bits_seen + 5'd1 : bits_seen;
        count_inc = (&match_count) ? match_count : match_count + 1'b1;

        // stop outranks both start and an incoming bit.
        accept    = (state == RUN) && bus.bit_valid && !bus.stop;
        hit       = accept && (seen_inc >= len_q)
                    && (((new_hist ^ pat_q) & len_mask) == '0);
        thr_hit   = hit && (thr_q != '0) && (count_inc == thr_q);
        start_run = bus.start && !bus.stop && (state != RUN);

        cfg_idle  = (state == IDLE) && bus.cfg_we;
        cfg_bad   = cfg_idle && ((bus.cfg_len < 5'd2) || (bus.cfg_len > 5'(MAX_LEN)));

        case (state)
            IDLE: if (start_run) state_next = RUN;
            RUN: begin
                if (bus.stop)    state_next = IDLE;
                else if (thr_hit) state_next = DONE;
            end
            DONE: begin
                if (bus.stop)       state_next = IDLE;
                else if (bus.start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pat_q        <= '0;
            len_q        <= 5'd2;
            ovl_q        <= 1'b0;
            thr_q        <= '0;
            history      <= '0;
            bits_seen    <= '0;
            match_count  <= '0;
            detect_pulse <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            detect_pulse <= hit;
            cfg_err      <= cfg_bad;

            if (cfg_idle && !cfg_bad) begin
                pat_q <= bus.cfg_pattern;
                len_q <= bus.cfg_len;
                ovl_q <= bus.cfg_overlap;
                thr_q <= bus.cfg_threshold;
            end

            if (start_run) begin
                history     <= '0;
                bits_seen   <= '0;
                match_count <= '0;
            end else if (accept) begin
                history   <= new_hist[MAX_LEN-2:0];
                // Non-overlap: forget the matched bits by restarting the fill count.
                bits_seen <= (hit && !ovl_q) ? 5'd0 : seen_inc;
                if (hit) match_count <= count_inc;
            end
        end
    end

    assign bus.bit_ready    = (state == RUN);
    assign bus.busy         = (state == RUN);
    assign bus.done         = (state == DONE);
    assign bus.detect_pulse = detect_pulse;
    assign bus.match_count  = match_count;
    assign bus.cfg_err      = cfg_err;

    a_done_not_ready: assert property (@(posedge clock) disable iff (!reset)
        bus.done |-> !bus.bit_ready);
    a_pulse_has_count: assert property (@(posedge clock) disable iff (!reset)
        detect_pulse |-> (match_count != '0));

endmodule
